// File: rtl/leaky_integrate_fire_neuron.sv
// Leaky integrate-and-fire neuron with binary weighted synapses.
// Each cycle either counts down a refractory period or evaluates
// integrate -> leak -> threshold on an externally held membrane potential.
// No handshake: the block evaluates every cycle (no valid/ready pair).
module leaky_integrate_fire_neuron #(
  parameter int NUM_INPUTS = 8,
  parameter int DATA_W     = 8,
  parameter int TREF_W     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_INPUTS-1:0]        spike_in,
  input  logic [NUM_INPUTS*DATA_W-1:0] weight,
  input  logic [DATA_W-1:0]            memb_potential_in,
  input  logic [DATA_W-1:0]            threshold,
  input  logic [DATA_W-1:0]            leak_value,
  input  logic [TREF_W-1:0]            tref,
  output logic [DATA_W-1:0]            memb_potential_out,
  output logic                         spike_out
);

  // Wide enough to hold the potential plus every weight without overflow.
  localparam int SUM_W = DATA_W + $clog2(NUM_INPUTS + 1);
  localparam logic [SUM_W-1:0] MAX_POT = SUM_W'({DATA_W{1'b1}});

  logic [TREF_W-1:0] ref_cnt;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  leaked;
  logic [DATA_W-1:0] clamped;
  logic              fire;

  // Integrate weighted spikes, apply the flooring leak, then compare.
  always_comb begin
    sum = SUM_W'(memb_potential_in);
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (spike_in[i]) begin
        sum = sum + SUM_W'(weight[i*DATA_W +: DATA_W]);
      end
    end
    if (sum >= SUM_W'(leak_value)) begin
      leaked = sum - SUM_W'(leak_value);
    end else begin
      leaked = '0;
    end
    fire = (leaked >= SUM_W'(threshold));
    // Only reachable if the threshold compare were ever bypassed; keeps
    // the output in range regardless.
    if (leaked > MAX_POT) begin
      clamped = {DATA_W{1'b1}};
    end else begin
      clamped = leaked[DATA_W-1:0];
    end
  end

  // Output and refractory registers; reset wins, refractory ignores inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      memb_potential_out <= '0;
      spike_out          <= 1'b0;
      ref_cnt            <= '0;
    end else if (ref_cnt != '0) begin
      memb_potential_out <= '0;
      spike_out          <= 1'b0;
      ref_cnt            <= ref_cnt - 1'b1;
    end else if (fire) begin
      memb_potential_out <= '0;
      spike_out          <= 1'b1;
      ref_cnt            <= tref;
    end else begin
      memb_potential_out <= clamped;
      spike_out          <= 1'b0;
      ref_cnt            <= ref_cnt;
    end
  end

endmodule

// File: tb/tb_leaky_integrate_fire_neuron.sv
// Self-checking bench for leaky_integrate_fire_neuron: directed scenarios
// plus randomized traffic against an arithmetic reference model.
module tb_leaky_integrate_fire_neuron;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int TW = 4;

  // Clock / reset block
  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    spike_in;
  logic [N*DW-1:0] weight;
  logic [DW-1:0]   memb_potential_in;
  logic [DW-1:0]   threshold;
  logic [DW-1:0]   leak_value;
  logic [TW-1:0]   tref;
  logic [DW-1:0]   memb_potential_out;
  logic            spike_out;

  always #5 clk = ~clk;

  leaky_integrate_fire_neuron #(.NUM_INPUTS(N), .DATA_W(DW), .TREF_W(TW)) dut (
    .clk               (clk),
    .reset             (reset),
    .spike_in          (spike_in),
    .weight            (weight),
    .memb_potential_in (memb_potential_in),
    .threshold         (threshold),
    .leak_value        (leak_value),
    .tref              (tref),
    .memb_potential_out(memb_potential_out),
    .spike_out         (spike_out)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: refractory cycles still owed, and expected outputs.
  int          m_ref = 0;
  logic [DW-1:0] exp_pot = '0;
  logic        exp_spk = 1'b0;

  // Reference model: apply the neuron's rules to the inputs about to be sampled.
  task automatic model_step();
    int s;
    int v;
    if (reset) begin
      m_ref = 0; exp_pot = '0; exp_spk = 1'b0;
    end else if (m_ref > 0) begin
      m_ref = m_ref - 1; exp_pot = '0; exp_spk = 1'b0;
    end else begin
      s = int'(memb_potential_in);
      for (int i = 0; i < N; i++)
        if (spike_in[i]) s = s + int'(weight[i*DW +: DW]);
      v = (s >= int'(leak_value)) ? s - int'(leak_value) : 0;
      if (v >= int'(threshold)) begin
        exp_spk = 1'b1; exp_pot = '0; m_ref = int'(tref);
      end else begin
        exp_spk = 1'b0;
        exp_pot = (v > 255) ? 8'hFF : v[DW-1:0];
      end
    end
  endtask

  // Driver: update model with current inputs, clock once, settle past the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    reset = 1'b0; spike_in = '0; weight = '0; memb_potential_in = '0;
    threshold = 8'h10; leak_value = 8'd1; tref = 4'd2;
  endtask

  task automatic set_ramp_weights();
    for (int i = 0; i < N; i++) weight[i*DW +: DW] = 8'(i + 1);
  endtask

  task automatic apply_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    spike_in = 8'($urandom); weight = 64'({$urandom, $urandom});
    memb_potential_in = 8'($urandom); threshold = 8'd0; tref = 4'hF;
    reset = 1'b1;
    tick();
    checks++;
    if (memb_potential_out !== 8'd0 || spike_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs pot=%0d spk=%0b required pot=0 spk=0", memb_potential_out, spike_out);
    end
    // Threshold 0: the first cycle after reset must be evaluated and fire.
    reset = 1'b0; threshold = 8'd0; spike_in = '0; memb_potential_in = '0;
    tick();
    checks++;
    if (spike_out !== 1'b1 || memb_potential_out !== 8'd0) begin
      errors++;
      $display("FAIL reset_next_evaluated pot=%0d spk=%0b required pot=0 spk=1", memb_potential_out, spike_out);
    end
  endtask

  task automatic test_ramp();
    logic [DW-1:0] want [6];
    want = '{8'd0, 8'd1, 8'd3, 8'd6, 8'd10, 8'd15};
    drive_idle(); set_ramp_weights(); apply_reset();
    for (int k = 0; k < 6; k++) begin
      spike_in = 8'(1 << k);
      memb_potential_in = exp_pot;
      tick();
      checks++;
      if (memb_potential_out !== want[k] || spike_out !== 1'b0 ||
          memb_potential_out !== exp_pot) begin
        errors++;
        $display("FAIL ramp_step%0d pot=%0d spk=%0b required pot=%0d spk=0", k, memb_potential_out, spike_out, want[k]);
      end
    end
  endtask

  // Continues directly from potential 15 left by test_ramp.
  task automatic test_fire_refractory();
    logic [N-1:0] pat [4];
    logic         want_spk [4];
    pat      = '{8'h40, 8'h80, 8'hC0, 8'hE0};
    want_spk = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      spike_in = pat[k];
      memb_potential_in = memb_potential_out;
      tick();
      checks++;
      if (spike_out !== want_spk[k] || memb_potential_out !== 8'd0) begin
        errors++;
        $display("FAIL fire_refr_step%0d pot=%0d spk=%0b required pot=0 spk=%0b", k, memb_potential_out, spike_out, want_spk[k]);
      end
    end
  endtask

  task automatic test_leak_floor();
    drive_idle(); apply_reset();
    memb_potential_in = 8'd2; leak_value = 8'd5; threshold = 8'h10;
    tick();
    checks++;
    if (memb_potential_out !== 8'd0 || spike_out !== 1'b0) begin
      errors++;
      $display("FAIL leak_floor pot=%0d spk=%0b required pot=0 spk=0", memb_potential_out, spike_out);
    end
  endtask

  task automatic test_saturation();
    drive_idle(); apply_reset();
    spike_in = 8'hFF; weight = {N*DW{1'b1}}; memb_potential_in = 8'hFF;
    threshold = 8'hFF; tref = 4'd0; leak_value = 8'd0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (spike_out !== 1'b1 || memb_potential_out !== 8'd0) begin
        errors++;
        $display("FAIL saturation_fire%0d pot=%0d spk=%0b required pot=0 spk=1", k, memb_potential_out, spike_out);
      end
    end
  endtask

  task automatic test_reset_mid_refractory();
    drive_idle(); set_ramp_weights(); apply_reset();
    tref = 4'hF; threshold = 8'd10; spike_in = 8'hFF;
    tick();
    checks++;
    if (spike_out !== 1'b1) begin
      errors++;
      $display("FAIL midref_initial_fire spk=%0b required 1", spike_out);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (spike_out !== 1'b0 || memb_potential_out !== 8'd0) begin
        errors++;
        $display("FAIL midref_refractory%0d pot=%0d spk=%0b required pot=0 spk=0", k, memb_potential_out, spike_out);
      end
    end
    reset = 1'b1; tick(); reset = 1'b0;
    spike_in = 8'hFF; memb_potential_in = '0;
    tick();
    checks++;
    if (spike_out !== 1'b1) begin
      errors++;
      $display("FAIL midref_after_reset spk=%0b required 1", spike_out);
    end
  endtask

  // Random traffic with feedback, tref changes mid-refractory and sporadic reset.
  task automatic test_random();
    drive_idle(); apply_reset();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 31) == 0);
      spike_in = 8'($urandom);
      for (int i = 0; i < N; i++) weight[i*DW +: DW] = 8'($urandom_range(0, 63));
      memb_potential_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : exp_pot;
      threshold  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(40, 255));
      leak_value = 8'($urandom_range(0, 40));
      tref       = 4'($urandom_range(0, 5));
      tick();
      checks++;
      if (memb_potential_out !== exp_pot || spike_out !== exp_spk) begin
        errors++;
        $display("FAIL random_cycle%0d pot=%0d spk=%0b required pot=%0d spk=%0b", c, memb_potential_out, spike_out, exp_pot, exp_spk);
      end
    end
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_ramp();
    test_fire_refractory();
    test_leak_floor();
    test_saturation();
    test_reset_mid_refractory();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Final report guard: never let the run hang.
  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
